// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encoding and defaults for the PC sequencer
package pc_sequencer_pkg;

   localparam int ADDR_W_DEF = 12;

   // 2'd3 is never entered on purpose; the sequencer treats it as BOOT
   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// rtl/pc_sequencer_ret_stack.sv - synchronous return-address LIFO
module ret_stack #(
   parameter int DEPTH = 4,
   parameter int W     = 12
) (
   input  logic                   iCLK,
   input  logic                   iRST_N,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [IW-1:0] top_idx;

   assign top_idx = IW'(count - CW'(1));
   assign dout    = mem[top_idx];
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);

   // contents are don't-care after reset, so only the occupancy is cleared
   always_ff @(posedge iCLK) begin
      if (iRST_N && push && !full)
         mem[count[IW-1:0]] <= din;
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N)
         count <= '0;
      else if (push && !full)
         count <= count + CW'(1);
      else if (pop && !empty)
         count <= count - CW'(1);
   end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-address stage feeding fetch: increment, jump, call/return, halt
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int               ADDR_W     = ADDR_W_DEF,
   parameter int               DEPTH      = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input  logic                   iCLK,
   input  logic                   iRST_N,
   input  logic                   iADV,
   input  logic                   iJUMP,
   input  logic                   iCALL,
   input  logic                   iRET,
   input  logic [ADDR_W-1:0]      iTARGET,
   input  logic                   iHALT,
   input  logic                   iRESUME,
   output logic [ADDR_W-1:0]      oADDR,
   output logic                   oFETCH_EN,
   output logic [$clog2(DEPTH):0] oSP,
   output logic                   oERR
);

   state_t                   state;
   logic                     go;
   logic                     push;
   logic                     pop;
   logic                     full;
   logic                     empty;
   logic [ADDR_W-1:0]        tos;
   logic [ADDR_W-1:0]        ret_addr;

   assign go       = (state == ST_RUN) && !iHALT && iADV;
   assign push     = go && !iRET && iCALL && !full;
   assign pop      = go && iRET && !empty;
   assign ret_addr = oADDR + ADDR_W'(1);

   ret_stack #(.DEPTH(DEPTH), .W(ADDR_W)) u_stack (
      .iCLK   (iCLK),
      .iRST_N (iRST_N),
      .push   (push),
      .pop    (pop),
      .din    (ret_addr),
      .dout   (tos),
      .count  (oSP),
      .full   (full),
      .empty  (empty)
   );

   // oFETCH_EN is registered alongside state so it is 1 exactly while in RUN
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state     <= ST_BOOT;
         oADDR     <= RESET_ADDR;
         oFETCH_EN <= 1'b0;
         oERR      <= 1'b0;
      end else begin
         case (state)
            ST_BOOT: begin
               state     <= ST_RUN;
               oFETCH_EN <= 1'b1;
            end
            ST_RUN: begin
               if (iHALT) begin
                  state     <= ST_HALT;
                  oFETCH_EN <= 1'b0;
               end else if (iADV) begin
                  if (iRET) begin
                     if (empty) begin
                        oERR      <= 1'b1;
                        state     <= ST_HALT;
                        oFETCH_EN <= 1'b0;
                     end else begin
                        oADDR <= tos;
                     end
                  end else if (iCALL) begin
                     if (full) begin
                        oERR      <= 1'b1;
                        state     <= ST_HALT;
                        oFETCH_EN <= 1'b0;
                     end else begin
                        oADDR <= iTARGET;
                     end
                  end else if (iJUMP) begin
                     oADDR <= iTARGET;
                  end else begin
                     oADDR <= ret_addr;
                  end
               end
            end
            ST_HALT: begin
               if (iRESUME) begin
                  state     <= ST_RUN;
                  oFETCH_EN <= 1'b1;
               end
            end
            default: begin
               state     <= ST_BOOT;
               oFETCH_EN <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer against a behavioural model
module tb_pc_sequencer;

   logic        iCLK = 1'b0;
   logic        iRST_N, iADV, iJUMP, iCALL, iRET, iHALT, iRESUME;
   logic [11:0] iTARGET;
   logic [11:0] oADDR;
   logic        oFETCH_EN;
   logic [2:0]  oSP;
   logic        oERR;

   pc_sequencer dut (
      .iCLK      (iCLK),
      .iRST_N    (iRST_N),
      .iADV      (iADV),
      .iJUMP     (iJUMP),
      .iCALL     (iCALL),
      .iRET      (iRET),
      .iTARGET   (iTARGET),
      .iHALT     (iHALT),
      .iRESUME   (iRESUME),
      .oADDR     (oADDR),
      .oFETCH_EN (oFETCH_EN),
      .oSP       (oSP),
      .oERR      (oERR)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      int addr;
      int fen;
      int sp;
      int err;
      int id;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_step = 0;

   // model: 0 = boot, 1 = run, 2 = halt
   int   m_mode = 0;
   int   m_pc   = 0;
   int   m_stk[$];
   int   m_err  = 0;

   task automatic chk(input string name, input int id, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s step %0d: got %0h, expected %0h", name, id, act, req);
      end
   endtask

   always @(posedge iCLK) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("oADDR", e.id, int'(oADDR), e.addr);
         chk("oFETCH_EN", e.id, int'(oFETCH_EN), e.fen);
         chk("oSP", e.id, int'(oSP), e.sp);
         chk("oERR", e.id, int'(oERR), e.err);
      end
   end

   task automatic model(input bit rst_n, adv, jmp, cal, rt, input int tgt, input bit hlt, res);
      if (!rst_n) begin
         m_mode = 0; m_pc = 0; m_err = 0; m_stk.delete();
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (hlt) m_mode = 2;
         else if (adv) begin
            if (rt) begin
               if (m_stk.size() == 0) begin m_err = 1; m_mode = 2; end
               else m_pc = m_stk.pop_back();
            end else if (cal) begin
               if (m_stk.size() == 4) begin m_err = 1; m_mode = 2; end
               else begin m_stk.push_back((m_pc + 1) % 4096); m_pc = tgt; end
            end else if (jmp) m_pc = tgt;
            else m_pc = (m_pc + 1) % 4096;
         end
      end else if (res) begin
         m_mode = 1;
      end
   endtask

   task automatic step(input bit rst_n, adv, jmp, cal, rt, input int tgt, input bit hlt, res);
      exp_t e;
      iRST_N = rst_n; iADV = adv; iJUMP = jmp; iCALL = cal; iRET = rt;
      iTARGET = 12'(tgt); iHALT = hlt; iRESUME = res;
      model(rst_n, adv, jmp, cal, rt, tgt, hlt, res);
      e.addr = m_pc; e.fen = (m_mode == 1) ? 1 : 0; e.sp = m_stk.size(); e.err = m_err;
      e.id = n_step++;
      exp_q.push_back(e);
      @(negedge iCLK);
   endtask

   task automatic rst_boot();
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic adv();              step(1, 1, 0, 0, 0, 0, 0, 0); endtask
   task automatic jump(input int t);  step(1, 1, 1, 0, 0, t, 0, 0); endtask
   task automatic call(input int t);  step(1, 1, 0, 1, 0, t, 0, 0); endtask
   task automatic ret();              step(1, 1, 0, 0, 1, 0, 0, 0); endtask
   task automatic resume();           step(1, 0, 0, 0, 0, 0, 0, 1); endtask

   initial begin
      step(0, 1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      repeat (5) adv();
      step(1, 0, 0, 0, 0, 0, 0, 0);
      jump(12'hFFE); adv(); adv();
      jump(12'h010); call(12'h200); adv(); adv(); ret();
      for (int i = 0; i < 5; i++) call(12'h300 + i);
      step(1, 1, 1, 1, 1, 12'h555, 0, 0);
      resume(); adv();
      rst_boot(); ret(); adv(); resume(); adv();
      rst_boot(); call(12'h0A0); step(1, 1, 1, 1, 1, 12'h0F0, 0, 0);
      jump(12'h020); step(1, 1, 0, 0, 0, 0, 1, 0);
      step(1, 1, 1, 0, 0, 12'h777, 1, 0); call(12'h123);
      resume(); adv(); adv();
      call(12'h100); call(12'h101); call(12'h102);
      step(0, 1, 0, 1, 0, 12'h400, 0, 0);
      adv(); adv();
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0,
              int'($urandom_range(0, 4095)),
              $urandom_range(0, 11) == 0,
              $urandom_range(0, 1) == 1);
      end
      @(posedge iCLK);
      #2;
      chk("drain", n_step, exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
